// File: rtl/pio_pixel_unpacker_pkg.sv
// Shared field layout, limits and FSM state type for the PIO pixel unpacker.
// The HPS packs up to 31 pixels per 256-bit PIO word behind a toggle strobe.
package pio_pixel_pkg;

    localparam int unsigned WORD_W   = 256;
    localparam int unsigned TOG_BIT  = 255;
    localparam int unsigned FS_BIT   = 254;
    localparam int unsigned RSVD_BIT = 253;
    localparam int unsigned NPIX_HI  = 252;
    localparam int unsigned NPIX_LO  = 248;
    localparam int unsigned NPIX_W   = NPIX_HI - NPIX_LO + 1;

    localparam int unsigned PIX_W       = 8;
    localparam int unsigned MAX_PIX     = 31;
    localparam int unsigned PIX_FIELD_W = MAX_PIX * PIX_W;
    localparam int unsigned IDX_W       = 5;
    localparam int unsigned DROP_W      = 16;
    localparam int unsigned POS_W       = 12;

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    // A count-minus-one of 31 would address a pixel slot that does not exist.
    function automatic logic [NPIX_W-1:0] clamp_npix_m1(input logic [NPIX_W-1:0] raw);
        logic [NPIX_W-1:0] lim;
        lim = NPIX_W'(MAX_PIX - 1);
        return (raw > lim) ? lim : raw;
    endfunction

endpackage

// File: rtl/pio_pixel_unpacker_if.sv
// Pixel stream handshake between the unpacker (master) and its consumer (slave).
interface pio_pixel_unpacker_if;
    import pio_pixel_pkg::*;

    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_sof;
    logic             pix_eol;
    logic             pix_eof;

    modport master (
        output pix_data,
        output pix_valid,
        output pix_sof,
        output pix_eol,
        output pix_eof,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pix_sof,
        input  pix_eol,
        input  pix_eof,
        output pix_ready
    );

endinterface

// File: rtl/pixel_pos_counter.sv
// Raster position tracker: x/y advance on each accepted pixel and drive the
// start-of-frame, end-of-line and end-of-frame markers for the current pixel.
module pixel_pos_counter
    import pio_pixel_pkg::*;
#(
    parameter int unsigned LINE_W  = 640,
    parameter int unsigned FRAME_H = 480
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_adv,
    input  logic i_valid,
    output logic o_sof,
    output logic o_eol,
    output logic o_eof
);

    localparam logic [POS_W-1:0] X_LAST = POS_W'(LINE_W - 1);
    localparam logic [POS_W-1:0] Y_LAST = POS_W'(FRAME_H - 1);

    logic [POS_W-1:0] r_x;
    logic [POS_W-1:0] r_y;
    logic [POS_W-1:0] w_x_d;
    logic [POS_W-1:0] w_y_d;
    logic             w_x_last;
    logic             w_y_last;

    assign w_x_last = (r_x == X_LAST);
    assign w_y_last = (r_y == Y_LAST);

    always_comb begin
        w_x_d = r_x;
        w_y_d = r_y;
        if (i_clr) begin
            w_x_d = '0;
            w_y_d = '0;
        end else if (i_adv) begin
            if (w_x_last) begin
                w_x_d = '0;
                w_y_d = w_y_last ? '0 : r_y + POS_W'(1);
            end else begin
                w_x_d = r_x + POS_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= w_x_d;
            r_y <= w_y_d;
        end
    end

    assign o_sof = i_valid && (r_x == '0) && (r_y == '0);
    assign o_eol = i_valid && w_x_last;
    assign o_eof = i_valid && w_x_last && w_y_last;

endmodule

// File: rtl/pio_pixel_unpacker.sv
// Serializes 256-bit HPS PIO words into an 8-bit valid/ready pixel stream.
// Words arrive by flipping bit 255; words landing while busy are counted and dropped.
module pio_pixel_unpacker
    import pio_pixel_pkg::*;
#(
    parameter int unsigned LINE_W  = 640,
    parameter int unsigned FRAME_H = 480
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [WORD_W-1:0]     in_data,
    pio_pixel_unpacker_if.master  pix,
    output logic                  busy,
    output logic [DROP_W-1:0]     drop_cnt
);

    state_e                 r_state;
    state_e                 w_state_d;
    logic                   r_tog;
    logic                   w_tog_d;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_d;
    logic [NPIX_W-1:0]      r_last;
    logic [NPIX_W-1:0]      w_last_d;
    logic [PIX_FIELD_W-1:0] r_pix;
    logic [PIX_FIELD_W-1:0] w_pix_d;
    logic [DROP_W-1:0]      r_drop;
    logic [DROP_W-1:0]      w_drop_d;

    logic w_new;
    logic w_send;
    logic w_xfer;
    logic w_frame_clr;
    logic w_sof;
    logic w_eol;
    logic w_eof;
    logic w_unused_rsvd;

    assign w_unused_rsvd = in_data[RSVD_BIT];

    assign w_new  = in_data[TOG_BIT] ^ r_tog;
    assign w_send = (r_state == StSend);
    assign w_xfer = w_send && pix.pix_ready;

    always_comb begin
        w_state_d   = r_state;
        w_tog_d     = r_tog;
        w_idx_d     = r_idx;
        w_last_d    = r_last;
        w_pix_d     = r_pix;
        w_drop_d    = r_drop;
        w_frame_clr = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_new) begin
                    w_state_d   = StSend;
                    w_tog_d     = in_data[TOG_BIT];
                    w_idx_d     = '0;
                    w_last_d    = clamp_npix_m1(in_data[NPIX_HI:NPIX_LO]);
                    w_pix_d     = in_data[PIX_FIELD_W-1:0];
                    w_frame_clr = in_data[FS_BIT];
                end
            end
            StSend: begin
                if (w_xfer) begin
                    if (r_idx == r_last) begin
                        w_state_d = StIdle;
                        w_idx_d   = '0;
                    end else begin
                        w_idx_d = r_idx + IDX_W'(1);
                    end
                end
                // The strobe is consumed even though the payload is lost.
                if (w_new) begin
                    w_tog_d = in_data[TOG_BIT];
                    if (r_drop != DROP_MAX) begin
                        w_drop_d = r_drop + DROP_W'(1);
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= StIdle;
            r_tog   <= 1'b0;
            r_idx   <= '0;
            r_last  <= '0;
            r_pix   <= '0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_d;
            r_tog   <= w_tog_d;
            r_idx   <= w_idx_d;
            r_last  <= w_last_d;
            r_pix   <= w_pix_d;
            r_drop  <= w_drop_d;
        end
    end

    pixel_pos_counter #(
        .LINE_W  (LINE_W),
        .FRAME_H (FRAME_H)
    ) u_pos (
        .i_clk   (clk_clk),
        .i_rst_n (reset_reset_n),
        .i_clr   (w_frame_clr),
        .i_adv   (w_xfer),
        .i_valid (w_send),
        .o_sof   (w_sof),
        .o_eol   (w_eol),
        .o_eof   (w_eof)
    );

    assign pix.pix_data  = r_pix[{r_idx, 3'b000} +: PIX_W];
    assign pix.pix_valid = w_send;
    assign pix.pix_sof   = w_sof;
    assign pix.pix_eol   = w_eol;
    assign pix.pix_eof   = w_eof;

    assign busy     = w_send;
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_pio_pixel_unpacker.sv
// Directed bench for pio_pixel_unpacker on a 4x2 raster: vector table for
// plain word streaming plus hand sequences for stalls, drops, reset and saturation.
module tb_pio_pixel_unpacker;

    logic         clk_clk;
    logic         reset_reset_n;
    logic [255:0] in_data;
    logic         busy;
    logic [15:0]  drop_cnt;

    int n_chk;
    int n_err;

    pio_pixel_unpacker_if u_if ();

    pio_pixel_unpacker #(
        .LINE_W  (4),
        .FRAME_H (2)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .in_data       (in_data),
        .pix           (u_if),
        .busy          (busy),
        .drop_cnt      (drop_cnt)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic [255:0] din;
        logic         rdy;
        logic [7:0]   data;
        logic         valid;
        logic         sof;
        logic         eol;
        logic         eof;
        logic         bsy;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_word(input logic tog, input logic fs,
                                             input logic [4:0] npm1, input logic [7:0] base,
                                             input logic [7:0] step);
        logic [255:0] w;
        w = '0;
        w[255] = tog;
        w[254] = fs;
        w[252:248] = npm1;
        for (int k = 0; k < 31; k++) w[8*k +: 8] = base + 8'(k) * step;
        return w;
    endfunction

    function automatic vec_t mk_vec(input logic [255:0] din, input logic rdy,
                                    input logic [7:0] data, input logic valid, input logic sof,
                                    input logic eol, input logic eof, input logic bsy);
        vec_t v;
        v.din = din; v.rdy = rdy; v.data = data; v.valid = valid;
        v.sof = sof; v.eol = eol; v.eof = eof; v.bsy = bsy;
        return v;
    endfunction

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] w;
        int           n;
        n_chk = 0;
        n_err = 0;
        reset_reset_n = 1'b0;
        in_data = '0;
        u_if.pix_ready = 1'b0;

        // Table: plain 4-pixel word, then a frame-start word that crosses a line.
        w = mk_word(1'b1, 1'b0, 5'd3, 8'h11, 8'h11);
        vecs[0] = mk_vec(w, 1'b1, 8'h11, 1, 1, 0, 0, 1);
        vecs[1] = mk_vec(w, 1'b1, 8'h22, 1, 0, 0, 0, 1);
        vecs[2] = mk_vec(w, 1'b1, 8'h33, 1, 0, 0, 0, 1);
        vecs[3] = mk_vec(w, 1'b1, 8'h44, 1, 0, 1, 0, 1);
        vecs[4] = mk_vec(w, 1'b1, 8'h00, 0, 0, 0, 0, 0);
        w = mk_word(1'b0, 1'b1, 5'd7, 8'hA0, 8'h01);
        for (int k = 0; k < 8; k++)
            vecs[5+k] = mk_vec(w, 1'b1, 8'hA0 + 8'(k), 1, k == 0, (k == 3) || (k == 7), k == 7, 1);
        vecs[13] = mk_vec(w, 1'b1, 8'h00, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk_clk);
        #1;
        chk("rst_valid", {31'd0, u_if.pix_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_data", {24'd0, u_if.pix_data}, 0);
        chk("rst_drop", {16'd0, drop_cnt}, 0);
        chk("rst_flags", {29'd0, u_if.pix_sof, u_if.pix_eol, u_if.pix_eof}, 0);
        reset_reset_n = 1'b1;
        step();
        chk("idle_valid", {31'd0, u_if.pix_valid}, 0);

        for (int i = 0; i < 14; i++) begin
            in_data = vecs[i].din;
            u_if.pix_ready = vecs[i].rdy;
            step();
            chk($sformatf("v%0d_valid", i), {31'd0, u_if.pix_valid}, {31'd0, vecs[i].valid});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].bsy});
            if (vecs[i].valid)
                chk($sformatf("v%0d_data", i), {24'd0, u_if.pix_data}, {24'd0, vecs[i].data});
            chk($sformatf("v%0d_flags", i), {29'd0, u_if.pix_sof, u_if.pix_eol, u_if.pix_eof},
                {29'd0, vecs[i].sof, vecs[i].eol, vecs[i].eof});
        end

        // Stall on the third pixel for five cycles.
        in_data = mk_word(1'b1, 1'b0, 5'd3, 8'h11, 8'h11);
        u_if.pix_ready = 1'b1;
        step();
        chk("stall_p0", {24'd0, u_if.pix_data}, 32'h11);
        chk("stall_sof", {31'd0, u_if.pix_sof}, 1);
        step();
        chk("stall_p1", {24'd0, u_if.pix_data}, 32'h22);
        step();
        u_if.pix_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_hold%0d", i), {23'd0, u_if.pix_valid, u_if.pix_data}, 32'h133);
            step();
        end
        chk("stall_hold5", {23'd0, u_if.pix_valid, u_if.pix_data}, 32'h133);
        u_if.pix_ready = 1'b1;
        step();
        chk("stall_p3", {24'd0, u_if.pix_data}, 32'h44);
        chk("stall_p3_flags", {29'd0, u_if.pix_sof, u_if.pix_eol, u_if.pix_eof}, 32'b010);
        step();
        chk("stall_done", {30'd0, u_if.pix_valid, busy}, 0);

        // npix_m1 = 31 clamps to 31 pixels; a second toggle mid-word is dropped.
        in_data = mk_word(1'b0, 1'b0, 5'd31, 8'h40, 8'h01);
        n = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            step();
            if (cyc == 4) in_data[255] = 1'b1;
            if (u_if.pix_valid) begin
                if (n < 31) chk($sformatf("drop_p%0d", n), {24'd0, u_if.pix_data}, 32'h40 + n);
                n++;
            end else if (n > 0) begin
                break;
            end
        end
        chk("drop_npix", n, 31);
        chk("drop_cnt1", {16'd0, drop_cnt}, 1);
        in_data = mk_word(1'b0, 1'b0, 5'd0, 8'h77, 8'h00);
        step();
        chk("after_drop_accept", {23'd0, u_if.pix_valid, u_if.pix_data}, 32'h177);
        step();
        chk("after_drop_idle", {31'd0, busy}, 0);
        chk("after_drop_cnt", {16'd0, drop_cnt}, 1);

        // Reset in the middle of a word, strobe left high across release.
        in_data = mk_word(1'b1, 1'b0, 5'd5, 8'h80, 8'h01);
        step();
        step();
        step();
        chk("pre_rst_p2", {24'd0, u_if.pix_data}, 32'h82);
        reset_reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, u_if.pix_valid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_drop", {16'd0, drop_cnt}, 0);
        step();
        step();
        reset_reset_n = 1'b1;
        step();
        chk("resend_p0", {23'd0, u_if.pix_valid, u_if.pix_data}, 32'h180);
        chk("resend_sof", {31'd0, u_if.pix_sof}, 1);
        for (int k = 1; k < 6; k++) begin
            step();
            chk($sformatf("resend_p%0d", k), {24'd0, u_if.pix_data}, 32'h80 + k);
            chk($sformatf("resend_eol%0d", k), {31'd0, u_if.pix_eol}, {31'd0, k == 3});
        end
        step();
        chk("resend_done", {31'd0, busy}, 0);

        // Hold a word with ready low and hammer the strobe past 16-bit range.
        in_data = mk_word(1'b0, 1'b0, 5'd0, 8'h5A, 8'h00);
        u_if.pix_ready = 1'b0;
        step();
        chk("sat_busy", {31'd0, busy}, 1);
        for (int i = 0; i < 70000; i++) begin
            in_data[255] = ~in_data[255];
            step();
            if (i == 99) chk("sat_cnt100", {16'd0, drop_cnt}, 100);
        end
        chk("sat_cnt", {16'd0, drop_cnt}, 32'hFFFF);
        chk("sat_data", {24'd0, u_if.pix_data}, 32'h5A);
        u_if.pix_ready = 1'b1;
        step();
        chk("sat_idle", {31'd0, busy}, 0);
        chk("sat_hold", {16'd0, drop_cnt}, 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
